// File: rtl/estagio_decodificacao.sv
// Decode/operand-issue stage feeding the ALU: register bank, busy scoreboard, hazard stall.
// Optional macro FORWARDING_EN lets a same-cycle writeback resolve source and WAW hazards.
module estagio_decodificacao #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 8,
   parameter int IMM_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [15:0]           instr,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [3:0]            codop,
   output logic [DATA_WIDTH-1:0] operando1,
   output logic [DATA_WIDTH-1:0] operando2,
   output logic [2:0]            rd_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  wb_valid,
   input  logic [2:0]            wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  illegal
);

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   function automatic logic [DATA_WIDTH-1:0] sign_ext(input logic [IMM_WIDTH-1:0] imm);
      return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   endfunction

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic                  out_valid_q, out_valid_d;
   logic [3:0]            codop_q, codop_d;
   logic [DATA_WIDTH-1:0] operando1_q, operando1_d;
   logic [DATA_WIDTH-1:0] operando2_q, operando2_d;
   logic [2:0]            rd_out_q, rd_out_d;
   logic                  illegal_q, illegal_d;

   logic [3:0]            op_s;
   logic [2:0]            rd_s, rs1_s, rs2_s;
   logic                  is_reg_s, is_imm_s, legal_s;
   logic                  hit_rs1_s, hit_rs2_s, hit_rd_s;
   logic                  busy_rs1_s, busy_rs2_s, busy_rd_s;
   logic [DATA_WIDTH-1:0] val_rs1_s, val_rs2_s;
   logic                  hazard_s, fire_s, issue_s;

   // Decode, operand read with optional bypass, and hazard detection
   always_comb begin
      op_s     = instr[15:12];
      rd_s     = instr[11:9];
      rs1_s    = instr[8:6];
      rs2_s    = instr[5:3];
      is_reg_s = (op_s[3:2] == 2'b00);
      is_imm_s = (op_s[3:2] == 2'b10);
      legal_s  = is_reg_s | is_imm_s;

      // A matching writeback only bypasses when forwarding is built in
      hit_rs1_s = FWD & wb_valid & (wb_rd == rs1_s) & (rs1_s != 3'd0);
      hit_rs2_s = FWD & wb_valid & (wb_rd == rs2_s) & (rs2_s != 3'd0);
      hit_rd_s  = FWD & wb_valid & (wb_rd == rd_s)  & (rd_s  != 3'd0);

      busy_rs1_s = busy_q[rs1_s] & (rs1_s != 3'd0) & ~hit_rs1_s;
      busy_rs2_s = busy_q[rs2_s] & (rs2_s != 3'd0) & ~hit_rs2_s;
      busy_rd_s  = busy_q[rd_s]  & (rd_s  != 3'd0) & ~hit_rd_s;

      val_rs1_s = hit_rs1_s ? wb_data : ((rs1_s == 3'd0) ? {DATA_WIDTH{1'b0}} : regs_q[rs1_s]);
      val_rs2_s = hit_rs2_s ? wb_data : ((rs2_s == 3'd0) ? {DATA_WIDTH{1'b0}} : regs_q[rs2_s]);

      hazard_s = legal_s & (busy_rs1_s | (is_reg_s & busy_rs2_s) | busy_rd_s);
      in_ready = reset_n & (~out_valid_q | out_ready) & ~hazard_s;
      fire_s   = in_valid & in_ready;
      issue_s  = fire_s & legal_s;
   end

   // Next-state for output bundle, scoreboard and register bank
   always_comb begin
      out_valid_d = out_valid_q;
      codop_d     = codop_q;
      operando1_d = operando1_q;
      operando2_d = operando2_q;
      rd_out_d    = rd_out_q;
      illegal_d   = fire_s & ~legal_s;
      busy_d      = busy_q;
      regs_d      = regs_q;

      if (issue_s) begin
         out_valid_d = 1'b1;
         operando1_d = val_rs1_s;
         rd_out_d    = rd_s;
         if (is_reg_s) begin
            codop_d     = op_s;
            operando2_d = val_rs2_s;
         end else begin
            codop_d     = {1'b0, op_s[2:0]};
            operando2_d = sign_ext(instr[IMM_WIDTH-1:0]);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      // Clear first so a same-register issue re-sets the bit
      if (wb_valid && (wb_rd != 3'd0)) begin
         busy_d[wb_rd] = 1'b0;
         regs_d[wb_rd] = wb_data;
      end else begin
         busy_d[0] = 1'b0;
      end

      if (issue_s && (rd_s != 3'd0)) begin
         busy_d[rd_s] = 1'b1;
      end else begin
         busy_d[0] = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         codop_q     <= 4'd0;
         operando1_q <= {DATA_WIDTH{1'b0}};
         operando2_q <= {DATA_WIDTH{1'b0}};
         rd_out_q    <= 3'd0;
         illegal_q   <= 1'b0;
         busy_q      <= {NUM_REGS{1'b0}};
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         out_valid_q <= out_valid_d;
         codop_q     <= codop_d;
         operando1_q <= operando1_d;
         operando2_q <= operando2_d;
         rd_out_q    <= rd_out_d;
         illegal_q   <= illegal_d;
         busy_q      <= busy_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign codop     = codop_q;
   assign operando1 = operando1_q;
   assign operando2 = operando2_q;
   assign rd_out    = rd_out_q;
   assign illegal   = illegal_q;

endmodule

// File: doc/estagio_decodificacao.md
Name: estagio_decodificacao

Overview:
Decode/operand-issue stage sitting directly upstream of the ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads an internal 8x16 register bank, tracks in-flight destinations with a busy scoreboard and stalls on hazards.
- Drives a registered codop/operando1/operando2/destination bundle to the ALU.
- Receives the ALU result back on a writeback port and updates the register bank.

Parameters:
DATA_WIDTH, 16, width of registers, operands and writeback data
NUM_REGS, 8, register count; fixed by the 3-bit register fields
IMM_WIDTH, 6, immediate field width, sign-extended to DATA_WIDTH

Ports:
clk  in  1  single clock, all state updates on rising edge
reset_n  in  1  synchronous reset, active-low
instr  in  16  instruction word
in_valid  in  1  instr is valid
in_ready  out  1  stage accepts instr this cycle
codop  out  4  ALU operation code
operando1  out  DATA_WIDTH  first ALU operand
operando2  out  DATA_WIDTH  second ALU operand
rd_out  out  3  destination register carried with the operation
out_valid  out  1  output bundle valid
out_ready  in  1  ALU stage consumes the bundle
wb_valid  in  1  writeback strobe
wb_rd  in  3  writeback register index
wb_data  in  DATA_WIDTH  writeback value
illegal  out  1  one-cycle pulse when an illegal opcode is consumed

Behaviour:
Instruction format:
- op=instr[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm=[5:0].
- op 0..3: register form; codop=op, operando2=R[rs2].
- op 8..11: immediate form; codop=op[2:0] zero-extended, operando2=sign_ext(imm).
- All other op values are illegal.

Register bank and scoreboard:
- r0 always reads 0, is never busy, and ignores writes.
- Writes are committed at the clock edge when wb_valid=1 and wb_rd!=0.

Hazards:
- Stall if rs1 is busy, or (register form) rs2 is busy, or rd!=0 and rd is busy.
- Immediate form does not check rs2.

Handshake:
- in_ready = reset_n & (!out_valid | out_ready) & !hazard.
- Transfer occurs when in_valid & in_ready.
- Latency is 1 cycle: a legal instruction accepted at edge N gives out_valid=1 after edge N.
- The output bundle holds stable while out_valid & !out_ready.
- out_valid drops the cycle after consumption when no new transfer occurs.

Issue:
- A legal transfer sets busy[rd] (rd!=0).
- A writeback clears busy[wb_rd].
- If both hit the same register in the same cycle, set wins and the register stays busy.
- A writeback to a non-busy register still writes data; busy stays 0.

Illegal opcode:
- The instruction is consumed (in_ready obeys normal rules, hazard checks skipped).
- No output and no scoreboard change.
- illegal=1 for exactly one cycle.

Reset (reset_n=0 at a rising edge):
- All registers become 0, all busy bits 0.
- out_valid=0, codop=0, operando1=0, operando2=0, rd_out=0, illegal=0.
- Any held output or pending scoreboard state is discarded.
- in_ready=0 while reset_n=0.

Optional Feature:
Macro FORWARDING_EN.
- Defined: a same-cycle writeback resolves hazards.
  - If wb_valid & wb_rd==rs1/rs2 (nonzero), the stage does not stall on that source and uses wb_data as the operand.
  - A same-cycle writeback to a busy rd also clears the WAW hazard; busy is then re-set by the issue.
- Undefined: no bypass. Busy bits are only cleared at the edge, so a dependent instruction issues at the earliest one cycle after the writeback and reads the updated bank.

Test Plan:
1. Reset, then write r1=5 and r2=3 via wb; issue op0 rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, codop=0, operando1=5, operando2=3, rd_out=3, busy[3]=1.
2. Issue op9 rd=4 rs1=1 imm=6'b111110 -> codop=1, operando1=5, operando2=16'hFFFE.
3. After test 1 (r3 busy), issue op0 rd=5 rs1=3 -> in_ready=0 until wb r3=8. With FORWARDING_EN: issues the same cycle as wb with operando1=8. Without: issues one cycle later with operando1=8.
4. Hold out_ready=0 for 3 cycles with out_valid=1 -> bundle unchanged and in_ready=0; out_ready=1 -> next instruction accepted the same cycle.
5. Issue op=4'hF -> illegal pulses one cycle, out_valid stays 0, no busy bit set; issue rd=0 -> r0 never busy and reads 0.
6. Assert reset_n=0 while out_valid=1 and r3 busy -> after the edge out_valid=0, all outputs 0, busy cleared, all registers read 0.
